flu_wb_arbiter: RTL
===================

FLU_WB_ARBITER -- requirements
Module: flu_wb_arbiter

Interface
REQ-001 SHALL have parameter NR_SRC, default 4, number of fixed-latency result sources (2..8).
REQ-002 SHALL have parameter DEPTH, default 2, per-source buffer entries (1..4).
REQ-003 SHALL have parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with the lowest index winning.
REQ-004 SHALL have port clk_i, input, 1, clock.
REQ-005 SHALL have port rst_ni, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i, input, 1, synchronous flush of all buffered results.
REQ-007 SHALL have port src_valid_i, input, NR_SRC, per-source result valid.
REQ-008 SHALL have port src_ready_o, output, NR_SRC, per-source buffer can accept.
REQ-009 SHALL have port src_result_i, input, NR_SRC x riscv::XLEN, per-source result.
REQ-010 SHALL have port src_trans_id_i, input, NR_SRC x TRANS_ID_BITS, per-source scoreboard ID.
REQ-011 SHALL have port src_ex_i, input, NR_SRC x exception_t, per-source exception.
REQ-012 SHALL have port wb_valid_o, input-side qualifier is none; output, 1, writeback valid.
REQ-013 SHALL have port wb_ready_i, input, 1, scoreboard accepts writeback.
REQ-014 SHALL have ports wb_result_o (XLEN), wb_trans_id_o (TRANS_ID_BITS), wb_ex_o (exception_t) and wb_src_o ($clog2(NR_SRC)); all are outputs carrying the granted entry.

Function
REQ-015 A push SHALL occur on source i when src_valid_i[i] && src_ready_o[i] && !flush_i.
REQ-016 src_ready_o[i] SHALL be 1 exactly when count[i] < DEPTH, with no dependence on wb_ready_i.
REQ-017 Each source buffer SHALL be a FIFO with count width $clog2(DEPTH+1) and read/write pointers that wrap modulo DEPTH.
REQ-018 Input-to-output latency SHALL be at least one cycle; there is no combinational bypass path.
REQ-019 wb_valid_o SHALL be 1 when any count[i] > 0, and outputs SHALL present the head entry of the granted source.
REQ-020 A pop of the granted source SHALL occur on wb_valid_o && wb_ready_i.
REQ-021 A simultaneous push and pop on one source SHALL leave its count unchanged.
REQ-022 Lock: once wb_valid_o rises with grant k, the grant SHALL hold at k until the handshake, even if a higher-priority source becomes non-empty.
REQ-023 With RR_EN=1, on handshake the priority pointer SHALL move to (k+1) mod NR_SRC; it SHALL hold while stalled or idle.
REQ-024 Round-robin selection SHALL pick the first non-empty source at or after the pointer, with wrap-around.
REQ-025 With RR_EN=0, the pointer SHALL be unused; the lock still applies.
REQ-026 When wb_valid_o=0, the data outputs SHALL be '0.
REQ-027 When flush_i=1, at the next edge all counts and pointers SHALL be 0, the RR pointer 0 and the lock cleared.
REQ-028 During a flush, pushes in that cycle SHALL be dropped and wb_ready_i SHALL be ignored.
REQ-029 Order SHALL be preserved within one source; no ordering is guaranteed across sources.

Reset
REQ-030 During reset, all counts, FIFO pointers, the RR pointer and the lock SHALL be 0.
REQ-031 During reset, src_ready_o SHALL be all-ones and wb_valid_o and all data outputs SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries with no writeback.
REQ-033 FIFO storage SHALL not be reset; it is reached only through count.

Structure
REQ-034 The FIFO SHALL be a sub-module fu_result_fifo (parameters DEPTH and a payload type) instantiated NR_SRC times.
REQ-035 A packed struct fu_wb_t {result, trans_id, ex} and the NR_SRC_MAX=8 constant SHALL reside in ariane_pkg; TRANS_ID_BITS and exception_t come from ariane_pkg.
REQ-036 The arbiter and lock logic SHALL reside in the top module.

Verification
REQ-037 Single push: push src2 (result=0xDEAD, id=3) with wb_ready=1 -> wb_valid=1 next cycle, wb_src=2, result=0xDEAD, id=3, then 0.
REQ-038 Round-robin fairness: all 4 sources full, wb_ready=1 continuously -> grant order 0,1,2,3,0,1,2,3, 8 writebacks.
REQ-039 Lock under stall: src3 pending, wb_ready=0 for 5 cycles, src0 pushes meanwhile -> wb_src stays 3 until the handshake, then 0.
REQ-040 Full and simultaneous push/pop: DEPTH=2, src1 full -> src_ready[1]=0; with a pop, src_ready returns to 1 next cycle; a push plus pop at count=1 keeps count=1.
REQ-041 Flush: 3 entries buffered plus a push in the flush cycle -> next cycle wb_valid=0, all src_ready=1, and no stale entry appears afterwards.
REQ-042 Fixed priority: RR_EN=0, src0 and src2 both pending -> src0 entries drain first, then src2.

Source files
------------

// File: rtl/flu_wb_arbiter_pkg.sv
// flu_wb_arbiter_pkg: shared types and helpers for the fixed-latency writeback arbiter.
//   riscv              : XLEN
//   ariane_pkg         : TRANS_ID_BITS, NR_SRC_MAX, exception_t, fu_wb_t (buffered writeback payload)
//   flu_wb_arbiter_pkg : first_set() rotating priority search used by the arbiter
package riscv;
    localparam int unsigned XLEN = 64;
endpackage

package ariane_pkg;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned NR_SRC_MAX    = 8;

    typedef struct packed {
        logic [riscv::XLEN-1:0] cause;
        logic [riscv::XLEN-1:0] tval;
        logic                   valid;
    } exception_t;

    typedef struct packed {
        logic [riscv::XLEN-1:0]   result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               ex;
    } fu_wb_t;
endpackage

package flu_wb_arbiter_pkg;
    localparam int unsigned IDX_W = $clog2(ariane_pkg::NR_SRC_MAX);

    // First set bit of mask[n-1:0] at or after start, wrapping; returns start when mask is empty.
    // Scanning offsets from the far end down lets the nearest hit overwrite the others.
    function automatic logic [IDX_W-1:0] first_set(
        input logic [ariane_pkg::NR_SRC_MAX-1:0] mask,
        input int                                n,
        input int                                start
    );
        logic [IDX_W-1:0] idx;
        first_set = IDX_W'(start);
        for (int j = ariane_pkg::NR_SRC_MAX - 1; j >= 0; j--) begin
            if (j < n) begin
                idx = IDX_W'((start + j) % n);
                if (mask[idx]) first_set = idx;
            end
        end
    endfunction
endpackage

// File: rtl/flu_wb_arbiter_fifo.sv
// fu_result_fifo: per-source result buffer with modulo-DEPTH pointers and unreset storage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of count and pointers
//   push_i        : write data_i (already qualified by the caller)
//   pop_i         : drop the head entry (caller only pops when non-empty)
//   data_o        : head entry, meaningful only while count_o != 0
//   count_o       : number of buffered entries
module fu_result_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  T                           data_i,
    output T                           data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    // Storage is only ever observed through count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr == PW'(DEPTH - 1) ? '0 : r_wptr + PW'(1);
            if (pop_i)  r_rptr <= r_rptr == PW'(DEPTH - 1) ? '0 : r_rptr + PW'(1);
            r_count <= r_count + CW'(push_i) - CW'(pop_i);
        end
    end

    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;
endmodule

// File: rtl/flu_wb_arbiter.sv
// flu_wb_arbiter: buffers results of NR_SRC fixed-latency units and arbitrates one writeback port.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   flush_i           : drop all buffered results, clear pointer and lock
//   src_valid_i/ready : per-source push handshake (ready = buffer not full)
//   src_result/trans_id/ex_i : per-source payload
//   wb_valid_o/ready_i: writeback handshake
//   wb_result/trans_id/ex/src_o : head entry of the granted source, zero while idle
module flu_wb_arbiter
    import ariane_pkg::*;
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NR_SRC = 4,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned RR_EN  = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [NR_SRC-1:0]          src_valid_i,
    output logic [NR_SRC-1:0]          src_ready_o,
    input  logic [riscv::XLEN-1:0]     src_result_i   [NR_SRC],
    input  logic [TRANS_ID_BITS-1:0]   src_trans_id_i [NR_SRC],
    input  exception_t                 src_ex_i       [NR_SRC],
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [riscv::XLEN-1:0]     wb_result_o,
    output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output exception_t                 wb_ex_o,
    output logic [$clog2(NR_SRC)-1:0]  wb_src_o
);
    localparam int unsigned SW = $clog2(NR_SRC);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fu_wb_t          w_in      [NR_SRC];
    fu_wb_t          w_head    [NR_SRC];
    logic [CW-1:0]   w_count   [NR_SRC];
    logic [NR_SRC-1:0] w_nonempty;
    logic [NR_SRC-1:0] w_push;
    logic [NR_SRC-1:0] w_pop;
    logic            w_valid;
    logic            w_hs;
    logic [SW-1:0]   w_pick;
    logic [SW-1:0]   w_grant;
    fu_wb_t          w_out;

    logic [SW-1:0]   r_ptr;
    logic            r_lock;
    logic [SW-1:0]   r_lock_src;

    for (genvar i = 0; i < NR_SRC; i++) begin : g_src
        assign w_in[i]        = '{result: src_result_i[i], trans_id: src_trans_id_i[i], ex: src_ex_i[i]};
        assign w_nonempty[i]  = w_count[i] != '0;
        assign src_ready_o[i] = w_count[i] < CW'(DEPTH);
        assign w_push[i]      = src_valid_i[i] && src_ready_o[i] && !flush_i;
        assign w_pop[i]       = w_hs && w_grant == SW'(i);

        fu_result_fifo #(
            .DEPTH (DEPTH),
            .T     (fu_wb_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (w_push[i]),
            .pop_i   (w_pop[i]),
            .data_i  (w_in[i]),
            .data_o  (w_head[i]),
            .count_o (w_count[i])
        );
    end

    assign w_valid = |w_nonempty;
    assign w_hs    = w_valid && wb_ready_i && !flush_i;

    // Fixed priority is round-robin with the search start pinned at source 0.
    assign w_pick  = SW'(first_set(NR_SRC_MAX'(w_nonempty), NR_SRC, RR_EN != 0 ? int'(r_ptr) : 0));
    // A stalled offer keeps its source so the writeback data stays stable until accepted.
    assign w_grant = r_lock ? r_lock_src : w_pick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_src <= '0;
        end else if (flush_i) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_src <= '0;
        end else begin
            r_lock     <= w_valid && !wb_ready_i;
            r_lock_src <= w_grant;
            if (w_hs && RR_EN != 0) r_ptr <= w_grant == SW'(NR_SRC - 1) ? '0 : w_grant + SW'(1);
        end
    end

    assign w_out         = w_valid ? w_head[w_grant] : '0;
    assign wb_valid_o    = w_valid;
    assign wb_result_o   = w_out.result;
    assign wb_trans_id_o = w_out.trans_id;
    assign wb_ex_o       = w_out.ex;
    assign wb_src_o      = w_valid ? w_grant : '0;
endmodule
